// File: rtl/prbs_checker_if.sv
// AXIS side of the PRBS checker: parameter word in, error and chip counters out.
interface prbs_checker_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    // Handshake: there is no tready on any stream. The checker samples PARAM tdata on
    // every clock whatever tvalid says, and holds ERR/BITS tvalid at 1 so a consumer may
    // take the current count on any cycle it chooses.
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PARAM_tdata;
    logic                        S_AXIS_PARAM_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_ERR_tdata;
    logic                        M_AXIS_ERR_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_BITS_tdata;
    logic                        M_AXIS_BITS_tvalid;
    logic [1:0]                  state_dbg;

    // master = PS/DMA side, slave = checker
    modport master (
        output S_AXIS_PARAM_tdata, S_AXIS_PARAM_tvalid,
        input  M_AXIS_ERR_tdata, M_AXIS_ERR_tvalid,
        input  M_AXIS_BITS_tdata, M_AXIS_BITS_tvalid,
        input  state_dbg
    );
    modport slave (
        input  S_AXIS_PARAM_tdata, S_AXIS_PARAM_tvalid,
        output M_AXIS_ERR_tdata, M_AXIS_ERR_tvalid,
        output M_AXIS_BITS_tdata, M_AXIS_BITS_tvalid,
        output state_dbg
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds a local LFSR from the received chips, hunts for
// lock, then free-runs and counts chip errors with a windowed loss-of-lock detector.
module prbs_checker #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LOCK_COUNT       = 64,
    parameter int WINDOW           = 256,
    parameter int UNLOCK_THRESH    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit_in,
    input  logic          bit_valid,
    input  logic          clear,
    output logic          locked,
    output logic          err_pulse,
    prbs_checker_if.slave axis
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        HUNT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_THRESH + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_THRESH - 1);

    state_t        state;
    logic [2:0]    sel_q;
    logic [2:0]    sel_new;
    logic [31:0]   hist;
    logic [31:0]   hist_shift;
    logic [5:0]    seq_len;
    logic [4:0]    seq_tap;
    logic [5:0]    fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;
    logic [31:0]   err_cnt;
    logic [31:0]   bits_cnt;
    logic          pred;
    logic          mism;
    logic          shift_bit;
    logic          unused_param;

    assign sel_new = axis.S_AXIS_PARAM_tdata[7:5];
    assign unused_param = ^{axis.S_AXIS_PARAM_tvalid,
                            axis.S_AXIS_PARAM_tdata[AXIS_TDATA_WIDTH-1:8],
                            axis.S_AXIS_PARAM_tdata[4:0]};

    always_comb begin
        seq_len = 6'd0;
        seq_tap = 5'd0;
        case (sel_q)
            3'd0: begin seq_len = 6'd8;  seq_tap = 5'd1; end
            3'd1: begin seq_len = 6'd10; seq_tap = 5'd4; end
            3'd2: begin seq_len = 6'd16; seq_tap = 5'd1; end
            3'd3: begin seq_len = 6'd24; seq_tap = 5'd5; end
            3'd4: begin seq_len = 6'd32; seq_tap = 5'd3; end
            default: ;
        endcase
    end

    assign pred      = hist[0] ^ hist[seq_tap];
    assign mism      = bit_in ^ pred;
    assign shift_bit = (state == LOCKED) ? pred : bit_in;

    // Bits at and above L stay zero (hist is cleared on every sel change), so a plain
    // right shift followed by writing slot L-1 gives {new, hist[L-1:1]}.
    always_comb begin
        hist_shift = hist >> 1;
        hist_shift[seq_len[4:0] - 5'd1] = shift_bit;
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= 3'd0;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_cnt   <= '0;
            bits_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            sel_q     <= sel_new;
            err_pulse <= 1'b0;
            if (sel_new != sel_q) begin
                state     <= (sel_new <= 3'd4) ? SEED : IDLE;
                hist      <= '0;
                fill_cnt  <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_q <= 3'd4) begin
                            state    <= SEED;
                            fill_cnt <= '0;
                        end
                    end
                    SEED: begin
                        if (bit_valid) begin
                            hist     <= hist_shift;
                            fill_cnt <= fill_cnt + 6'd1;
                            if (fill_cnt + 6'd1 == seq_len) begin
                                state     <= HUNT;
                                match_cnt <= '0;
                            end
                        end
                    end
                    HUNT: begin
                        if (bit_valid) begin
                            hist <= hist_shift;
                            if (mism) begin
                                match_cnt <= '0;
                            end else if (match_cnt == MATCH_LAST) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (bit_valid) begin
                            hist     <= hist_shift;
                            bits_cnt <= sat_inc(bits_cnt);
                            if (mism) begin
                                err_cnt   <= sat_inc(err_cnt);
                                err_pulse <= 1'b1;
                            end
                            if (mism && (win_err == ERR_LAST)) begin
                                state    <= SEED;
                                fill_cnt <= '0;
                                locked   <= 1'b0;
                            end else if (win_cnt == WIN_LAST) begin
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                win_cnt <= win_cnt + WW'(1);
                                win_err <= win_err + EW'(mism);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // Last assignment wins: a clear on the same cycle as a counted chip reads 0.
            if (clear) begin
                err_cnt  <= '0;
                bits_cnt <= '0;
            end
        end
    end

    assign axis.M_AXIS_ERR_tdata   = AXIS_TDATA_WIDTH'(err_cnt);
    assign axis.M_AXIS_BITS_tdata  = AXIS_TDATA_WIDTH'(bits_cnt);
    assign axis.M_AXIS_ERR_tvalid  = 1'b1;
    assign axis.M_AXIS_BITS_tvalid = 1'b1;
    assign axis.state_dbg          = state;
endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table-driven lock-time vectors, hand-written error/unlock/clear
// sequences and randomized chip streams, all checked against a queue-based chip model.
module tb_prbs_checker;
    localparam int W             = 32;
    localparam int LOCK_COUNT    = 64;
    localparam int WINDOW        = 256;
    localparam int UNLOCK_THRESH = 16;

    logic clk = 1'b0;
    logic rst;
    logic bit_in;
    logic bit_valid;
    logic clear;
    logic locked;
    logic err_pulse;

    prbs_checker_if #(.AXIS_TDATA_WIDTH(W)) axis_if ();

    prbs_checker #(
        .AXIS_TDATA_WIDTH(W),
        .LOCK_COUNT(LOCK_COUNT),
        .WINDOW(WINDOW),
        .UNLOCK_THRESH(UNLOCK_THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .clear(clear),
        .locked(locked),
        .err_pulse(err_pulse),
        .axis(axis_if)
    );

    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    // ---------------- transmitter: r[n] = r[n-L] ^ r[n-L+T] ----------------
    bit g_q[$];
    int g_t;

    function automatic void gen_init(input int len, input int tap);
        g_q.delete();
        g_t = tap;
        for (int i = 0; i < len; i++) g_q.push_back(1'($urandom_range(0, 1)));
        g_q[len-1] = 1'b1;
    endfunction

    // jump=1 flips the transmitter's own chip, so later chips follow the flipped value
    function automatic bit gen_next(input bit jump);
        bit b;
        b = g_q[0] ^ g_q[g_t] ^ jump;
        void'(g_q.pop_front());
        g_q.push_back(b);
        return b;
    endfunction

    // ---------------- reference model of the checker ----------------
    int         m_sel;
    int         m_len;
    int         m_tap;
    int         m_phase;   // 0 idle, 1 filling, 2 hunting, 3 locked
    bit         m_hist[$]; // front = oldest chip
    int         m_streak;
    int         m_win_chips;
    int         m_win_errs;
    logic [31:0] m_err;
    logic [31:0] m_bits;
    bit         m_locked;
    bit         m_pulse;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic void model_sel(input int s);
        int lens[5] = '{8, 10, 16, 24, 32};
        int taps[5] = '{1, 4, 1, 5, 3};
        m_sel = s;
        m_hist.delete();
        m_locked = 1'b0;
        m_pulse  = 1'b0;
        if (s <= 4) begin
            m_len = lens[s];
            m_tap = taps[s];
            m_phase = 1;
        end else begin
            m_phase = 0;
        end
    endfunction

    function automatic void model_reset();
        m_err = '0;
        m_bits = '0;
        model_sel(m_sel);
    endfunction

    function automatic void model_chip(input bit b, input bit clr);
        bit p;
        m_pulse = 1'b0;
        case (m_phase)
            1: begin
                m_hist.push_back(b);
                if (m_hist.size() == m_len) begin
                    m_phase = 2;
                    m_streak = 0;
                end
            end
            2: begin
                p = m_hist[0] ^ m_hist[m_tap];
                void'(m_hist.pop_front());
                m_hist.push_back(b);
                if (b == p) begin
                    m_streak++;
                    if (m_streak == LOCK_COUNT) begin
                        m_phase = 3;
                        m_locked = 1'b1;
                        m_win_chips = 0;
                        m_win_errs = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            3: begin
                p = m_hist[0] ^ m_hist[m_tap];
                void'(m_hist.pop_front());
                m_hist.push_back(p);
                m_bits = sat(m_bits);
                m_win_chips++;
                if (b != p) begin
                    m_err = sat(m_err);
                    m_pulse = 1'b1;
                    m_win_errs++;
                end
                if (m_win_errs == UNLOCK_THRESH) begin
                    m_phase = 1;
                    m_hist.delete();
                    m_locked = 1'b0;
                end else if (m_win_chips == WINDOW) begin
                    m_win_chips = 0;
                    m_win_errs = 0;
                end
            end
            default: ;
        endcase
        if (clr) begin
            m_err = '0;
            m_bits = '0;
        end
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        if (err_pulse === 1'b1) pulse_cnt++;
        check({tag, ".locked"}, 32'(locked), 32'(m_locked));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        check({tag, ".err_cnt"}, axis_if.M_AXIS_ERR_tdata, m_err);
        check({tag, ".bits_cnt"}, axis_if.M_AXIS_BITS_tdata, m_bits);
    endtask

    task automatic send_chip(input bit b, input bit clr, input int gap);
        bit_in = b;
        bit_valid = 1'b1;
        clear = clr;
        model_chip(b, clr);
        tick();
        bit_valid = 1'b0;
        clear = 1'b0;
        bit_in = 1'($urandom_range(0, 1));
        check_outputs("chip");
        for (int i = 1; i < gap; i++) begin
            m_pulse = 1'b0;
            tick();
            check_outputs("gap");
        end
    endtask

    task automatic send_line(input bit line_err, input int gap);
        send_chip(gen_next(1'b0) ^ line_err, 1'b0, gap);
    endtask

    task automatic set_sel(input logic [2:0] s, input int len, input int tap);
        axis_if.S_AXIS_PARAM_tdata = ($urandom() & 32'hFFFF_FF1F) | (32'(s) << 5);
        axis_if.S_AXIS_PARAM_tvalid = 1'($urandom_range(0, 1));
        if (int'(s) != m_sel) model_sel(int'(s));
        gen_init(len, tap);
        repeat (3) begin
            m_pulse = 1'b0;
            tick();
            check_outputs("sel");
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        m_err = '0;
        m_bits = '0;
        m_pulse = 1'b0;
        tick();
        clear = 1'b0;
        check_outputs("clear");
    endtask

    // Feeds clean chips one per 4 clk until locked rises (bounded), then checks the count.
    task automatic run_to_lock(input string name, input int exp_chips, input int budget);
        int n;
        int got;
        n = 0;
        got = 0;
        while (n < budget && got == 0) begin
            send_line(1'b0, 4);
            n++;
            if (locked === 1'b1) got = n;
        end
        check({name, " lock chips"}, 32'(got), 32'(exp_chips));
    endtask

    typedef struct {
        logic [2:0] sel;
        int         len;
        int         tap;
        int         exp_lock; // 0: must never lock
    } lock_vec_t;

    initial begin
        #(8 * 60000);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        lock_vec_t vecs[6];
        int        rate;
        bit        e;
        vecs[0] = '{3'd0, 8, 1, 72};
        vecs[1] = '{3'd1, 10, 4, 74};
        vecs[2] = '{3'd2, 16, 1, 80};
        vecs[3] = '{3'd3, 24, 5, 88};
        vecs[4] = '{3'd4, 32, 3, 96};
        vecs[5] = '{3'd6, 8, 1, 0};

        // ---- clock/reset ----
        rst = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        clear = 1'b0;
        axis_if.S_AXIS_PARAM_tdata = '0;
        axis_if.S_AXIS_PARAM_tvalid = 1'b0;
        m_sel = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset locked", 32'(locked), 32'd0);
        check("reset err_pulse", 32'(err_pulse), 32'd0);
        check("reset err_cnt", axis_if.M_AXIS_ERR_tdata, 32'd0);
        check("reset bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'd0);
        check("reset err_tvalid", 32'(axis_if.M_AXIS_ERR_tvalid), 32'd1);
        check("reset bits_tvalid", 32'(axis_if.M_AXIS_BITS_tvalid), 32'd1);
        rst = 1'b0;
        gen_init(8, 1);
        repeat (3) begin tick(); check_outputs("post-reset"); end

        // ---- lock time per sel; 5 chips counted after each lock ----
        for (int v = 0; v < 6; v++) begin
            set_sel(vecs[v].sel, vecs[v].len, vecs[v].tap);
            run_to_lock($sformatf("sel%0d", vecs[v].sel), vecs[v].exp_lock,
                        (vecs[v].exp_lock == 0) ? 120 : vecs[v].exp_lock + 20);
            if (vecs[v].exp_lock != 0) repeat (5) send_line(1'b0, 4);
        end
        check("idle locked", 32'(locked), 32'd0);
        check("idle err frozen", axis_if.M_AXIS_ERR_tdata, 32'd0);
        check("idle bits frozen", axis_if.M_AXIS_BITS_tdata, 32'd25);

        // ---- 16 errors in one window drop lock; relock keeps the count ----
        set_sel(3'd0, 8, 1);
        run_to_lock("sel0 relock", 72, 92);
        do_clear();
        for (int i = 0; i < 31; i++) send_line(i % 2 == 0, 4);
        check("unlock locked", 32'(locked), 32'd0);
        check("unlock err_cnt", axis_if.M_AXIS_ERR_tdata, 32'd16);
        check("unlock bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'd31);
        run_to_lock("after unlock", 72, 92);
        check("relock err kept", axis_if.M_AXIS_ERR_tdata, 32'd16);

        // ---- single line error: one pulse, no error multiplication ----
        do_clear();
        repeat (20) send_line(1'b0, 4);
        pulse_cnt = 0;
        send_line(1'b1, 4);
        repeat (40) send_line(1'b0, 4);
        check("single pulses", 32'(pulse_cnt), 32'd1);
        check("single err_cnt", axis_if.M_AXIS_ERR_tdata, 32'd1);
        check("single bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'd61);
        check("single locked", 32'(locked), 32'd1);

        // ---- HUNT mismatch after 63 matches restarts the streak ----
        set_sel(3'd1, 10, 4);
        set_sel(3'd0, 8, 1);
        for (int i = 0; i < 135; i++) send_chip(gen_next(i == 71), 1'b0, 4);
        check("hunt 135 locked", 32'(locked), 32'd0);
        send_line(1'b0, 4);
        check("hunt 136 locked", 32'(locked), 32'd1);

        // ---- saturation, then clear coincident with an error chip ----
        force dut.err_cnt = 32'hFFFF_FFFF;
        force dut.bits_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.err_cnt;
        release dut.bits_cnt;
        m_err = 32'hFFFF_FFFF;
        m_bits = 32'hFFFF_FFFF;
        send_line(1'b1, 4);
        check("sat err_cnt", axis_if.M_AXIS_ERR_tdata, 32'hFFFF_FFFF);
        check("sat bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'hFFFF_FFFF);
        send_chip(gen_next(1'b0) ^ 1'b1, 1'b1, 4);
        check("clr err_cnt", axis_if.M_AXIS_ERR_tdata, 32'd0);
        check("clr bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'd0);
        send_line(1'b0, 4);
        check("resume bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'd1);

        // ---- randomized chip stream, light then heavy line errors ----
        set_sel(3'd2, 16, 1);
        for (int i = 0; i < 1500; i++) begin
            rate = (i < 700) ? 2 : 9;
            e = ($urandom_range(0, 99) < rate);
            send_chip(gen_next(1'b0) ^ e, ($urandom_range(0, 199) == 0), $urandom_range(1, 4));
        end

        // ---- asynchronous reset while locked ----
        set_sel(3'd0, 8, 1);
        run_to_lock("pre-reset", 72, 92);
        bit_in = gen_next(1'b0) ^ 1'b1;
        bit_valid = 1'b1;
        model_chip(bit_in, 1'b0);
        tick();
        bit_valid = 1'b0;
        check_outputs("pre-reset err");
        #2;
        rst = 1'b1;
        #1;
        check("async rst locked", 32'(locked), 32'd0);
        check("async rst err_pulse", 32'(err_pulse), 32'd0);
        check("async rst err_cnt", axis_if.M_AXIS_ERR_tdata, 32'd0);
        check("async rst bits_cnt", axis_if.M_AXIS_BITS_tdata, 32'd0);
        check("async rst tvalid", 32'({axis_if.M_AXIS_ERR_tvalid, axis_if.M_AXIS_BITS_tvalid}), 32'd3);
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) begin tick(); check_outputs("rst release"); end
        run_to_lock("post-reset", 72, 92);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
